seq_checker: RTL and testbench
==============================

# seq_checker

Player-input checker for the memory-sequence game; it reads the one-hot sequence ROM and compares it against the player's button presses. For each round it walks `seq_addr` from 0 to `level`, waits for one clean press per step, and compares the press with the ROM word `seq_data`. It reports a one-cycle pass or fail verdict to the game controller. It sits between the synchronized button inputs and the game control FSM.

## Interface
- `TIMEOUT_CYCLES`, default 50_000_000: idle cycles allowed per step before the round fails.
- `TMR_W`, default 26: timeout counter width; must satisfy 2^TMR_W > TIMEOUT_CYCLES.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: begins a round; sampled only in IDLE.
- `level` input 4: index of the last step in the round, so the round has level+1 steps (1..16); latched when `start` is accepted.
- `buttons` input 4: active-high buttons, already synchronized and debounced upstream.
- `seq_addr` output 4: registered ROM address.
- `seq_data` input 4: one-hot expected value; combinational ROM output for `seq_addr`.
- `busy` output 1: high in every state except IDLE.
- `step_ok` output 1: one-cycle pulse per correct press.
- `round_ok` output 1: one-cycle pulse; all steps matched.
- `round_fail` output 1: one-cycle pulse; wrong press, multi-button press, or timeout.

## Operation
- States: IDLE, ARM, WAIT_PRESS, CHECK, PASS, FAIL.
- **IDLE**
  - On `start`: latch `level` into `level_q`, clear `seq_addr`, clear the timer, go to ARM.
- **ARM** (release wait)
  - If `buttons == 0`, go to WAIT_PRESS.
  - The timer counts here, so a stuck button eventually fails the round.
- **WAIT_PRESS**
  - On `buttons != 0`: capture `buttons` into `press_q`, go to CHECK.
  - If the timer reaches TIMEOUT_CYCLES-1 with no press, go to FAIL.
- **CHECK**
  - If `press_q` is not one-hot, go to FAIL.
  - Else if `press_q != seq_data`, go to FAIL.
  - Else if `seq_addr == level_q`, go to PASS.
  - Else increment `seq_addr`, clear the timer, go to ARM.
- **PASS / FAIL**: each lasts one cycle, then IDLE.
- `start` is ignored while `busy` is high. `level` changes after acceptance have no effect.
- `seq_addr` holds its final value in PASS, FAIL and IDLE until the next accepted `start`.
- The timer is a saturating up-counter. It counts in ARM and WAIT_PRESS and is held cleared in all other states.

## Timing
- Reset values: state IDLE; `seq_addr` = 0; `press_q` = 0; timer = 0; `busy`, `step_ok`, `round_ok`, `round_fail` = 0.
- Reset asserted mid-round aborts immediately. No verdict pulse is produced.
- `start` accepted at edge E:
  - `busy` is high from E.
  - The round is in ARM from E.
- Press first sampled nonzero in WAIT_PRESS at edge N:
  - CHECK occupies cycle N..N+1.
  - The verdict state is entered at N+1.
  - `round_ok` or `round_fail` is high for exactly the cycle after N+1.
  - `busy` drops at N+2.
- `step_ok` is registered: high for one cycle after every matching CHECK, including the final step. It therefore coincides with `round_ok` on the last step.
- `seq_addr` updates at the edge that leaves CHECK. `seq_data` must settle within the same cycle, since the ROM is combinational.
- Minimum step time is 3 cycles (ARM, WAIT_PRESS, CHECK) when buttons are already released.
- Timeout boundary:
  - A press sampled on the same edge the timer reaches TIMEOUT_CYCLES-1 wins and goes to CHECK.
  - The timeout fires only when no press is present on that edge.
- `level` = 15 checks all 16 addresses, 0..15. `seq_addr` never wraps within a round.

## Structure
- Shared package `game_pkg`:
  - state encoding (3-bit localparams),
  - the default TIMEOUT_CYCLES,
  - an `is_onehot4` function reused by the controller.
- One sub-module, `step_timer`:
  - ports: `clear`, `enable`, `expired`;
  - parameterized by TIMEOUT_CYCLES and TMR_W.
- Everything else lives in a single FSM module.

## Test plan
- **Single correct step.** Setup: ROM model with 0:0001, 1:1000, 2:0100, 3:1000; TIMEOUT_CYCLES=20. Stimulus: `level`=0, `start`, then press 0001. Expected: `step_ok` and `round_ok` on the same cycle, two cycles after the press edge; `busy` low one cycle later.
- **Three-step pass.** Stimulus: `level`=2; presses 0001, 1000, 0100, each followed by a release. Expected: `seq_addr` steps 0→1→2; three `step_ok` pulses; one `round_ok`; no `round_fail`.
- **Wrong press.** Stimulus: `level`=2; press 0001, release, press 0010. Expected: `round_fail` two cycles after the second press; `seq_addr` holds 1; exactly one `step_ok`.
- **Multi-button press.** Stimulus: press 0011 at step 0. Expected: `round_fail`; no `step_ok`.
- **Timeout and stuck button.**
  - No press for 20 cycles: `round_fail` follows.
  - Button held through ARM: also fails after 20 cycles.
  - Press on the exact expiry edge: handled as a press, not a timeout.
- **Reset and ignored start.**
  - `rst_n` pulsed low mid-round: all outputs reset asynchronously; no verdict pulse.
  - `start` while `busy`: ignored.
  - `level` changed mid-round: no effect.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the memory-sequence game: state encoding, default
// step timeout and the one-hot test used when judging a press.
package game_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARM   = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_CHECK = 3'd3;
  localparam logic [2:0] ST_PASS  = 3'd4;
  localparam logic [2:0] ST_FAIL  = 3'd5;

  typedef enum logic [2:0] {
    IDLE       = ST_IDLE,
    ARM        = ST_ARM,
    WAIT_PRESS = ST_WAIT,
    CHECK      = ST_CHECK,
    PASS       = ST_PASS,
    FAIL       = ST_FAIL
  } state_t;

  localparam int TIMEOUT_DEFAULT = 50_000_000;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/step_timer.sv
// Saturating per-step idle counter; expired stays high once the last allowed
// cycle has been reached, until the owner clears it.
module step_timer
  import game_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  parameter int TMR_W          = 26
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != LAST)) begin
      cnt <= cnt + TMR_W'(1);
    end
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/seq_checker.sv
// Player-input checker: walks the sequence ROM one step per clean press and
// reports a one-cycle pass/fail verdict for the round.
module seq_checker
  import game_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  parameter int TMR_W          = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] level,
  input  logic [3:0] buttons,
  output logic [3:0] seq_addr,
  input  logic [3:0] seq_data,
  output logic       busy,
  output logic       step_ok,
  output logic       round_ok,
  output logic       round_fail
);

  state_t     state, state_n;
  logic [3:0] level_q;
  logic [3:0] press_q;
  logic       expired;
  logic       tmr_run;
  logic       match;
  logic       any_press;

  assign any_press = (buttons != 4'd0);
  assign match     = is_onehot4(press_q) && (press_q == seq_data);
  assign tmr_run   = (state == ARM) || (state == WAIT_PRESS);

  step_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TMR_W         (TMR_W)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (!tmr_run),
    .enable (tmr_run),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      level_q  <= '0;
      press_q  <= '0;
      seq_addr <= '0;
      step_ok  <= 1'b0;
    end else begin
      state   <= state_n;
      step_ok <= (state == CHECK) && match;
      if ((state == IDLE) && start) begin
        level_q  <= level;
        seq_addr <= '0;
      end else if ((state == CHECK) && match && (seq_addr != level_q)) begin
        seq_addr <= seq_addr + 4'd1;
      end
      if ((state == WAIT_PRESS) && any_press) begin
        press_q <= buttons;
      end
    end
  end

  // A press present on the expiry edge takes priority over the timeout.
  always_comb begin
    state_n    = state;
    busy       = (state != IDLE);
    round_ok   = (state == PASS);
    round_fail = (state == FAIL);
    case (state)
      IDLE:       if (start) state_n = ARM;
      ARM: begin
        if (!any_press)   state_n = WAIT_PRESS;
        else if (expired) state_n = FAIL;
      end
      WAIT_PRESS: begin
        if (any_press)    state_n = CHECK;
        else if (expired) state_n = FAIL;
      end
      CHECK: begin
        if (!match)                   state_n = FAIL;
        else if (seq_addr == level_q) state_n = PASS;
        else                          state_n = ARM;
      end
      PASS:       state_n = IDLE;
      FAIL:       state_n = IDLE;
      default:    state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_checker.sv
// Self-checking bench for seq_checker: directed rounds plus randomized rounds
// judged by a round-level reference model of the game rules.
module tb_seq_checker;

  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [3:0] level = 4'd0;
  logic [3:0] buttons = 4'd0;
  logic [3:0] seq_addr;
  logic [3:0] seq_data;
  logic       busy, step_ok, round_ok, round_fail;

  logic [3:0] rom [16];
  int errors = 0;
  int checks = 0;
  int n_step = 0, n_ok = 0, n_fail = 0;

  always #5 clk = ~clk;

  assign seq_data = rom[seq_addr];

  seq_checker #(.TIMEOUT_CYCLES(TO), .TMR_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .level     (level),
    .buttons   (buttons),
    .seq_addr  (seq_addr),
    .seq_data  (seq_data),
    .busy      (busy),
    .step_ok   (step_ok),
    .round_ok  (round_ok),
    .round_fail(round_fail)
  );

  always @(negedge clk) begin
    if (step_ok === 1'b1)    n_step++;
    if (round_ok === 1'b1)   n_ok++;
    if (round_fail === 1'b1) n_fail++;
  end

  // Round outcome from the game rules: the first press that is not exactly the
  // ROM word (which is one-hot) ends the round in failure.
  function automatic void model_round(input int lvl, input logic [3:0] pr [16],
                                      output int nsteps, output bit pass, output int last);
    for (int i = 0; i <= lvl; i++) begin
      if ($countones(pr[i]) != 1 || pr[i] != rom[i]) begin
        nsteps = i; pass = 1'b0; last = i;
        return;
      end
    end
    nsteps = lvl + 1; pass = 1'b1; last = lvl;
  endfunction

  task automatic load_rom_fixed();
    rom[0] = 4'b0001; rom[1] = 4'b1000; rom[2] = 4'b0100; rom[3] = 4'b1000;
    for (int i = 4; i < 16; i++) rom[i] = 4'b0001 << $urandom_range(0, 3);
  endtask

  task automatic start_round(input logic [3:0] lvl);
    @(negedge clk); level = lvl; start = 1'b1;
    @(negedge clk); start = 1'b0; level = 4'($urandom);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL start_busy: got %b want 1", busy); end
    @(negedge clk);
  endtask

  task automatic run_round(input string name, input int lvl, input logic [3:0] pr [16],
                           input int gap [16], input int hold [16]);
    int nsteps, last, used, s0, o0, f0;
    bit pass, fin;
    model_round(lvl, pr, nsteps, pass, last);
    used = pass ? lvl + 1 : nsteps + 1;
    s0 = n_step; o0 = n_ok; f0 = n_fail;
    start_round(4'(lvl));
    for (int i = 0; i < used; i++) begin
      fin = (i == used - 1);
      repeat (gap[i]) @(negedge clk);
      checks++;
      if (seq_addr !== 4'(i)) begin
        errors++; $display("FAIL %s addr step %0d: got %0d want %0d", name, i, seq_addr, i);
      end
      buttons = pr[i];
      @(negedge clk);
      if (hold[i] <= 1) buttons = 4'd0;
      @(negedge clk);
      checks++;
      if (step_ok !== (i < nsteps)) begin
        errors++; $display("FAIL %s step_ok step %0d: got %b want %b", name, i, step_ok, (i < nsteps));
      end
      checks++;
      if (round_ok !== (fin && pass)) begin
        errors++; $display("FAIL %s round_ok step %0d: got %b want %b", name, i, round_ok, fin && pass);
      end
      checks++;
      if (round_fail !== (fin && !pass)) begin
        errors++; $display("FAIL %s round_fail step %0d: got %b want %b", name, i, round_fail, fin && !pass);
      end
      repeat (hold[i] > 2 ? hold[i] - 2 : 0) @(negedge clk);
      buttons = 4'd0;
      @(negedge clk);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_end: got %b want 0", name, busy); end
    checks++;
    if (seq_addr !== 4'(last)) begin
      errors++; $display("FAIL %s final_addr: got %0d want %0d", name, seq_addr, last);
    end
    @(negedge clk);
    checks++;
    if ((n_step - s0) != nsteps || (n_ok - o0) != int'(pass) || (n_fail - f0) != int'(!pass)) begin
      errors++;
      $display("FAIL %s pulse_counts: got step=%0d ok=%0d fail=%0d want step=%0d ok=%0d fail=%0d",
               name, n_step - s0, n_ok - o0, n_fail - f0, nsteps, int'(pass), int'(!pass));
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (step_ok !== 1'b0)    begin errors++; $display("FAIL rst_step_ok: got %b want 0", step_ok); end
    checks++; if (round_ok !== 1'b0)   begin errors++; $display("FAIL rst_round_ok: got %b want 0", round_ok); end
    checks++; if (round_fail !== 1'b0) begin errors++; $display("FAIL rst_round_fail: got %b want 0", round_fail); end
    checks++; if (seq_addr !== 4'd0)   begin errors++; $display("FAIL rst_addr: got %0d want 0", seq_addr); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [3:0] pr [16];
    int g [16], h [16];
    load_rom_fixed();
    for (int i = 0; i < 16; i++) begin pr[i] = rom[i]; g[i] = 0; h[i] = 1; end
    run_round("single", 0, pr, g, h);
    run_round("three_step", 2, pr, g, h);
    pr[1] = 4'b0010;
    run_round("wrong_press", 2, pr, g, h);
    pr[0] = 4'b0011;
    run_round("multi_button", 2, pr, g, h);
  endtask

  task automatic test_timeout();
    int f0;
    // Silence, stuck button, and a press landing on the expiry edge.
    for (int mode = 0; mode < 3; mode++) begin
      f0 = n_fail;
      buttons = (mode == 1) ? 4'b0001 : 4'b0000;
      @(negedge clk); level = 4'd0; start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (TO - 1) @(negedge clk);
      checks++;
      if (round_fail !== 1'b0) begin errors++; $display("FAIL timeout_early mode %0d: got %b want 0", mode, round_fail); end
      if (mode == 2) buttons = rom[0];
      @(negedge clk);
      checks++;
      if (round_fail !== (mode != 2)) begin
        errors++; $display("FAIL timeout_edge mode %0d: got %b want %b", mode, round_fail, mode != 2);
      end
      buttons = 4'd0;
      @(negedge clk);
      if (mode == 2) begin
        checks++;
        if (round_ok !== 1'b1 || step_ok !== 1'b1) begin
          errors++; $display("FAIL expiry_press: got ok=%b step=%b want ok=1 step=1", round_ok, step_ok);
        end
        @(negedge clk);
      end
      checks++;
      if (busy !== 1'b0 || (n_fail - f0) != int'(mode != 2)) begin
        errors++; $display("FAIL timeout_end mode %0d: got busy=%b fails=%0d", mode, busy, n_fail - f0);
      end
    end
  endtask

  task automatic test_mid_reset();
    int o0, f0;
    o0 = n_ok; f0 = n_fail;
    start_round(4'd2);
    buttons = rom[0];
    @(negedge clk); buttons = 4'd0;
    @(negedge clk);
    checks++;
    if (step_ok !== 1'b1 || seq_addr !== 4'd1) begin
      errors++; $display("FAIL mid_pre: got step=%b addr=%0d want step=1 addr=1", step_ok, seq_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || step_ok !== 1'b0 || seq_addr !== 4'd0) begin
      errors++; $display("FAIL mid_async: got busy=%b step=%b addr=%0d want 0 0 0", busy, step_ok, seq_addr);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ((n_ok - o0) != 0 || (n_fail - f0) != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_verdict: got ok=%0d fail=%0d busy=%b want 0 0 0", n_ok - o0, n_fail - f0, busy);
    end
  endtask

  task automatic test_ignored_start();
    start_round(4'd2);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        start = 1'b1; level = 4'd0;
        @(negedge clk); start = 1'b0;
        checks++;
        if (seq_addr !== 4'd1 || busy !== 1'b1) begin
          errors++; $display("FAIL busy_start: got addr=%0d busy=%b want 1 1", seq_addr, busy);
        end
      end
      buttons = rom[i];
      @(negedge clk); buttons = 4'd0;
      @(negedge clk);
      checks++;
      if (step_ok !== 1'b1 || round_ok !== (i == 2) || round_fail !== 1'b0) begin
        errors++;
        $display("FAIL ignored_start step %0d: got step=%b ok=%b fail=%b want 1 %b 0", i, step_ok, round_ok, round_fail, i == 2);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    logic [3:0] pr [16];
    int g [16], h [16];
    int lvl;
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < 16; i++) begin
        rom[i] = 4'b0001 << $urandom_range(0, 3);
        pr[i]  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : rom[i];
        g[i]   = $urandom_range(0, 3);
        h[i]   = $urandom_range(1, 3);
      end
      lvl = $urandom_range(0, 15);
      run_round("random", lvl, pr, g, h);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 4'b0001;
    test_reset();
    test_directed();
    test_timeout();
    test_mid_reset();
    test_ignored_start();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
